// File: rtl/magic_cfg_readback_pkg.sv
// Shared constants and types for the magic configuration readback path.
package magic_cfg_readback_pkg;

  localparam logic [7:0] CFG_PORT_LO = 8'hFF;

  localparam logic [7:0] CFG_IDX_REBOOT    = 8'h00;
  localparam logic [7:0] CFG_IDX_BEEPER    = 8'h01;
  localparam logic [7:0] CFG_IDX_TIMINGS   = 8'h02;
  localparam logic [7:0] CFG_IDX_TURBO     = 8'h03;
  localparam logic [7:0] CFG_IDX_MIX       = 8'h04;
  localparam logic [7:0] CFG_IDX_ROM_PLUS3 = 8'h05;
  localparam logic [7:0] CFG_IDX_ROM_ALT48 = 8'h06;
  localparam logic [7:0] CFG_IDX_JOY       = 8'h07;
  localparam logic [7:0] CFG_IDX_RAM_MODE  = 8'h08;
  localparam logic [7:0] CFG_IDX_DIVMMC    = 8'h09;
  localparam logic [7:0] CFG_IDX_EVENTS    = 8'h0A;
  localparam logic [7:0] CFG_IDX_ID        = 8'h0B;

  typedef enum logic [1:0] {
    TIM_48K  = 2'd0,
    TIM_128K = 2'd1,
    TIM_PENT = 2'd2,
    TIM_P3   = 2'd3
  } timings_t;

  typedef enum logic [1:0] {
    TURBO_X1 = 2'd0,
    TURBO_X2 = 2'd1,
    TURBO_X4 = 2'd2,
    TURBO_X8 = 2'd3
  } turbo_t;

  typedef enum logic [1:0] {
    RAM_48   = 2'd0,
    RAM_128  = 2'd1,
    RAM_P3   = 2'd2,
    RAM_PENT = 2'd3
  } rammode_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } rb_state_t;

  function automatic logic [7:0] zext1(input logic b);
    return {7'b0, b};
  endfunction

endpackage

// File: rtl/cpu_bus.sv
// CPU bus bundle as seen by IO responders.
interface cpu_bus;
  logic        ioreq;
  logic        rd;
  logic        wr;
  logic [15:0] a_reg;

  modport mon (input ioreq, rd, wr, a_reg);
  modport drv (output ioreq, rd, wr, a_reg);
endinterface

// File: rtl/magic_cfg_readback_btn_conditioner.sv
// Magic button synchroniser with optional debounce and rising-edge pulse.
// Debounce is enabled by defining MAGIC_CFG_READBACK_DEBOUNCE_EN.
module magic_cfg_readback_btn_conditioner #(
  parameter int unsigned DEBOUNCE_W = 16
) (
  input  logic clk28,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_rise
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;

  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
  end

`ifdef MAGIC_CFG_READBACK_DEBOUNCE_EN
  logic                  level_q, level_d;
  logic [DEBOUNCE_W-1:0] cnt_q, cnt_d;

  // Counter runs only while the input disagrees with the level; any agreement restarts it.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == '1) level_d = sync2_q;
      else             cnt_d   = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk28) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    btn_level = level_q;
    btn_rise  = level_d & ~level_q;
  end
`else
  localparam int unsigned UNUSED_DEBOUNCE_W = DEBOUNCE_W;

  always_ff @(posedge clk28) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  always_comb begin
    btn_level = sync2_q;
    btn_rise  = sync1_q & ~sync2_q;
  end
`endif

endmodule

// File: rtl/magic_cfg_readback.sv
// IO-read responder for the magic config port xxFF plus magic-button event tracking.
// Optional debounce: define MAGIC_CFG_READBACK_DEBOUNCE_EN.
module magic_cfg_readback
  import magic_cfg_readback_pkg::*;
#(
  parameter logic [7:0]  ID_BYTE    = 8'h5A,
  parameter int unsigned DEBOUNCE_W = 16
) (
  input  logic       clk28,
  input  logic       rst,
  cpu_bus.mon        bus,
  input  logic       magic_map,
  input  logic       magic_button,
  input  logic       magic_reboot,
  input  logic       magic_beeper,
  input  logic       rom_plus3,
  input  logic       rom_alt48,
  input  logic       joy_sinclair,
  input  logic       divmmc_en,
  input  logic       mix_abc,
  input  logic       mix_mono,
  input  timings_t   timings,
  input  turbo_t     turbo,
  input  rammode_t   ram_mode,
  output logic [7:0] d_out,
  output logic       d_oe,
  output logic       btn_level
);

  rb_state_t  state_q, state_d;
  logic [7:0] d_out_q, d_out_d;
  logic       d_oe_q, d_oe_d;
  logic [7:0] idx_q, idx_d;
  logic       sticky_q, sticky_d;
  logic [3:0] press_cnt_q, press_cnt_d;

  logic       btn_rise;
  logic       hit;
  logic       clear_sticky;
  logic [7:0] rd_data;
  logic       unused_wr;

  assign unused_wr = bus.wr;

  magic_cfg_readback_btn_conditioner #(
    .DEBOUNCE_W (DEBOUNCE_W)
  ) u_btn (
    .clk28     (clk28),
    .rst       (rst),
    .btn_raw   (magic_button),
    .btn_level (btn_level),
    .btn_rise  (btn_rise)
  );

  assign hit = magic_map && bus.ioreq && bus.rd && (bus.a_reg[7:0] == CFG_PORT_LO);

  always_comb begin
    rd_data = 8'hFF;
    case (bus.a_reg[15:8])
      CFG_IDX_REBOOT:    rd_data = zext1(magic_reboot);
      CFG_IDX_BEEPER:    rd_data = zext1(magic_beeper);
      CFG_IDX_TIMINGS:   rd_data = {6'b0, timings};
      CFG_IDX_TURBO:     rd_data = {6'b0, turbo};
      CFG_IDX_MIX:       rd_data = {6'b0, mix_mono, mix_abc};
      CFG_IDX_ROM_PLUS3: rd_data = zext1(rom_plus3);
      CFG_IDX_ROM_ALT48: rd_data = zext1(rom_alt48);
      CFG_IDX_JOY:       rd_data = zext1(joy_sinclair);
      CFG_IDX_RAM_MODE:  rd_data = {6'b0, ram_mode};
      CFG_IDX_DIVMMC:    rd_data = zext1(divmmc_en);
      CFG_IDX_EVENTS:    rd_data = {press_cnt_q, 2'b00, btn_level, sticky_q};
      CFG_IDX_ID:        rd_data = ID_BYTE;
      default:           rd_data = 8'hFF;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    d_out_d      = d_out_q;
    d_oe_d       = d_oe_q;
    idx_d        = idx_q;
    sticky_d     = sticky_q;
    press_cnt_d  = press_cnt_q;
    clear_sticky = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (hit) begin
          idx_d   = bus.a_reg[15:8];
          d_out_d = rd_data;
          d_oe_d  = 1'b1;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (!magic_map) begin
          d_out_d = 8'hFF;
          d_oe_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (!bus.ioreq) begin
          d_out_d = 8'hFF;
          d_oe_d  = 1'b0;
          state_d = ST_IDLE;
          // Clear only what the CPU actually saw: bit 0 of the frozen byte.
          clear_sticky = (idx_q == CFG_IDX_EVENTS) && d_out_q[0];
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (clear_sticky) sticky_d = 1'b0;
    if (btn_rise) begin
      sticky_d    = 1'b1;
      press_cnt_d = press_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk28) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      d_out_q     <= 8'hFF;
      d_oe_q      <= 1'b0;
      idx_q       <= '0;
      sticky_q    <= 1'b0;
      press_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      d_out_q     <= d_out_d;
      d_oe_q      <= d_oe_d;
      idx_q       <= idx_d;
      sticky_q    <= sticky_d;
      press_cnt_q <= press_cnt_d;
    end
  end

  assign d_out = d_out_q;
  assign d_oe  = d_oe_q;

endmodule

// File: tb/tb_magic_cfg_readback.sv
// Scoreboard bench for magic_cfg_readback: stimulus pushes expected bytes, a monitor checks responses.
`timescale 1ns/1ps
module tb_magic_cfg_readback;
  import magic_cfg_readback_pkg::*;

`ifdef MAGIC_CFG_READBACK_DEBOUNCE_EN
  localparam int SETTLE = 24;
`else
  localparam int SETTLE = 4;
`endif

  logic clk28 = 1'b0;
  always #18 clk28 = ~clk28;

  logic       rst;
  logic       magic_map, magic_button;
  logic       magic_reboot, magic_beeper, rom_plus3, rom_alt48;
  logic       joy_sinclair, divmmc_en, mix_abc, mix_mono;
  logic [1:0] timings_v, turbo_v, ram_mode_v;
  logic [7:0] d_out;
  logic       d_oe, btn_level;

  cpu_bus bus_if ();

  magic_cfg_readback #(
    .ID_BYTE    (8'h5A),
    .DEBOUNCE_W (4)
  ) dut (
    .clk28        (clk28),
    .rst          (rst),
    .bus          (bus_if),
    .magic_map    (magic_map),
    .magic_button (magic_button),
    .magic_reboot (magic_reboot),
    .magic_beeper (magic_beeper),
    .rom_plus3    (rom_plus3),
    .rom_alt48    (rom_alt48),
    .joy_sinclair (joy_sinclair),
    .divmmc_en    (divmmc_en),
    .mix_abc      (mix_abc),
    .mix_mono     (mix_mono),
    .timings      (timings_t'(timings_v)),
    .turbo        (turbo_t'(turbo_v)),
    .ram_mode     (rammode_t'(ram_mode_v)),
    .d_out        (d_out),
    .d_oe         (d_oe),
    .btn_level    (btn_level)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state: press count (mod 16), sticky event flag, settled button level.
  int m_cnt    = 0;
  bit m_sticky = 0;
  bit m_level  = 0;

  logic [7:0] exp_q[$];
  logic [7:0] cur_exp = 8'hFF;
  logic       oe_prev = 1'b0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%02h expected=%02h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] model_byte(input logic [7:0] idx);
    logic [3:0] c;
    c = 4'(m_cnt % 16);
    case (idx)
      8'h00: return {7'b0, magic_reboot};
      8'h01: return {7'b0, magic_beeper};
      8'h02: return {6'b0, timings_v};
      8'h03: return {6'b0, turbo_v};
      8'h04: return {6'b0, mix_mono, mix_abc};
      8'h05: return {7'b0, rom_plus3};
      8'h06: return {7'b0, rom_alt48};
      8'h07: return {7'b0, joy_sinclair};
      8'h08: return {6'b0, ram_mode_v};
      8'h09: return {7'b0, divmmc_en};
      8'h0A: return {c, 2'b00, m_level, m_sticky};
      8'h0B: return 8'h5A;
      default: return 8'hFF;
    endcase
  endfunction

  // Monitor: pops an expectation on each new response, then insists the byte stays frozen.
  always @(negedge clk28) begin
    if (d_oe && !oe_prev) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_response actual=%02h expected=none", d_out);
      end else begin
        cur_exp = exp_q.pop_front();
        if (d_out !== cur_exp) begin
          failures++;
          $display("FAIL read_data actual=%02h expected=%02h", d_out, cur_exp);
        end
      end
    end else if (d_oe && oe_prev) begin
      checks++;
      if (d_out !== cur_exp) begin
        failures++;
        $display("FAIL hold_frozen actual=%02h expected=%02h", d_out, cur_exp);
      end
    end
    oe_prev = d_oe;
  end

  task automatic randomize_cfg();
    magic_reboot = 1'($urandom);
    magic_beeper = 1'($urandom);
    rom_plus3    = 1'($urandom);
    rom_alt48    = 1'($urandom);
    joy_sinclair = 1'($urandom);
    divmmc_en    = 1'($urandom);
    mix_abc      = 1'($urandom);
    mix_mono     = 1'($urandom);
    timings_v    = 2'($urandom);
    turbo_v      = 2'($urandom);
    ram_mode_v   = 2'($urandom);
  endtask

  task automatic do_in(input logic [15:0] addr, input int hold_extra, input bit wiggle);
    logic [7:0] e;
    logic [7:0] idx;
    @(posedge clk28); #1;
    idx = addr[15:8];
    e   = model_byte(idx);
    exp_q.push_back(e);
    bus_if.ioreq = 1'b1; bus_if.rd = 1'b1; bus_if.wr = 1'b0; bus_if.a_reg = addr;
    @(posedge clk28); #1;
    check("latency_oe", {7'b0, d_oe}, 8'h01);
    for (int i = 0; i < hold_extra; i++) begin
      if (wiggle) randomize_cfg();
      @(posedge clk28); #1;
    end
    bus_if.ioreq = 1'b0; bus_if.rd = 1'b0;
    @(posedge clk28); #1;
    check("release_oe", {7'b0, d_oe}, 8'h00);
    if (idx == 8'h0A && e[0]) m_sticky = 0;
  endtask

  task automatic release_btn();
    magic_button = 1'b0;
    repeat (SETTLE) @(posedge clk28);
    #1;
    m_level = 0;
    check("btn_level_lo", {7'b0, btn_level}, 8'h00);
  endtask

  task automatic press(input bit keep);
    magic_button = 1'b1;
    repeat (SETTLE) @(posedge clk28);
    #1;
    m_cnt = (m_cnt + 1) % 16; m_sticky = 1; m_level = 1;
    check("btn_level_hi", {7'b0, btn_level}, 8'h01);
    if (!keep) release_btn();
  endtask

  initial begin
    rst = 1'b1;
    magic_map = 1'b0; magic_button = 1'b0;
    magic_reboot = 0; magic_beeper = 0; rom_plus3 = 0; rom_alt48 = 0;
    joy_sinclair = 0; divmmc_en = 0; mix_abc = 0; mix_mono = 0;
    timings_v = 0; turbo_v = 0; ram_mode_v = 0;
    bus_if.ioreq = 0; bus_if.rd = 0; bus_if.wr = 0; bus_if.a_reg = '0;
    repeat (3) @(posedge clk28);
    #1;
    check("reset_d_out", d_out, 8'hFF);
    check("reset_d_oe", {7'b0, d_oe}, 8'h00);
    check("reset_btn_level", {7'b0, btn_level}, 8'h00);
    rst = 1'b0;
    magic_map = 1'b1;
    do_in(16'h0AFF, 0, 0);

    // Config mirror
    turbo_v = 2'b10; ram_mode_v = 2'b01;
    do_in(16'h03FF, 2, 0);
    do_in(16'h08FF, 1, 1);

    // Gating: unmapped read and mapped write must not respond
    magic_map = 1'b0;
    @(posedge clk28); #1;
    bus_if.ioreq = 1; bus_if.rd = 1; bus_if.a_reg = 16'h02FF;
    repeat (3) @(posedge clk28);
    #1;
    check("gate_unmapped_oe", {7'b0, d_oe}, 8'h00);
    bus_if.ioreq = 0; bus_if.rd = 0;
    @(posedge clk28); #1;
    magic_map = 1'b1;

    // Events: two presses, third held through the reads
    press(0); press(0); press(1);
    @(posedge clk28); #1;
    bus_if.ioreq = 1; bus_if.wr = 1; bus_if.rd = 0; bus_if.a_reg = 16'h0AFF;
    repeat (3) @(posedge clk28);
    #1;
    check("gate_write_oe", {7'b0, d_oe}, 8'h00);
    bus_if.ioreq = 0; bus_if.wr = 0;
    do_in(16'h0AFF, 1, 0);
    do_in(16'h0AFF, 1, 0);
    release_btn();
    for (int i = 0; i < 16; i++) press(0);
    do_in(16'h0AFF, 0, 0);

`ifndef MAGIC_CFG_READBACK_DEBOUNCE_EN
    // Race: button edge lands in the same clock the clear-on-read fires
    press(0);
    @(posedge clk28); #1;
    exp_q.push_back(model_byte(8'h0A));
    bus_if.ioreq = 1; bus_if.rd = 1; bus_if.a_reg = 16'h0AFF;
    @(posedge clk28); #1;
    check("race_latency_oe", {7'b0, d_oe}, 8'h01);
    magic_button = 1'b1;
    @(posedge clk28); #1;
    bus_if.ioreq = 0; bus_if.rd = 0;
    @(posedge clk28); #1;
    check("race_release_oe", {7'b0, d_oe}, 8'h00);
    m_cnt = (m_cnt + 1) % 16; m_sticky = 1; m_level = 1;
    repeat (SETTLE) @(posedge clk28);
    #1;
    release_btn();
    do_in(16'h0AFF, 0, 0);
`endif

    // magic_map drop mid-HOLD: no clear-on-read
    press(0);
    @(posedge clk28); #1;
    exp_q.push_back(model_byte(8'h0A));
    bus_if.ioreq = 1; bus_if.rd = 1; bus_if.a_reg = 16'h0AFF;
    @(posedge clk28); #1;
    magic_map = 1'b0;
    @(posedge clk28); #1;
    check("map_drop_oe", {7'b0, d_oe}, 8'h00);
    bus_if.ioreq = 0; bus_if.rd = 0;
    @(posedge clk28); #1;
    magic_map = 1'b1;
    do_in(16'h0AFF, 0, 0);

    // Misc
    do_in(16'h0BFF, 0, 0);
    do_in(16'h42FF, 0, 0);

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      logic [15:0] a;
      randomize_cfg();
      if ($urandom_range(0, 5) == 0) press(0);
      else begin
        a = {8'($urandom_range(0, 15)), 8'hFF};
        if ($urandom_range(0, 7) == 0) a[15:8] = 8'($urandom);
        do_in(a, int'($urandom_range(0, 3)), 1'($urandom));
      end
    end

    // Reset mid-HOLD
    press(0);
    @(posedge clk28); #1;
    exp_q.push_back(model_byte(8'h0B));
    bus_if.ioreq = 1; bus_if.rd = 1; bus_if.a_reg = 16'h0BFF;
    @(posedge clk28); #1;
    check("rst_pre_oe", {7'b0, d_oe}, 8'h01);
    rst = 1'b1;
    @(posedge clk28); #1;
    check("rst_mid_hold_oe", {7'b0, d_oe}, 8'h00);
    check("rst_mid_hold_d_out", d_out, 8'hFF);
    rst = 1'b0; bus_if.ioreq = 0; bus_if.rd = 0;
    m_cnt = 0; m_sticky = 0; m_level = 0;
    do_in(16'h0AFF, 0, 0);
    do_in(16'h05FF, 1, 0);

`ifdef MAGIC_CFG_READBACK_DEBOUNCE_EN
    // Glitch shorter than the debounce window: no edge
    magic_button = 1'b1;
    repeat (10) @(posedge clk28);
    #1;
    magic_button = 1'b0;
    repeat (24) @(posedge clk28);
    #1;
    check("glitch_level", {7'b0, btn_level}, 8'h00);
    do_in(16'h0AFF, 0, 0);
    magic_button = 1'b1;
    repeat (20) @(posedge clk28);
    #1;
    check("stable_level", {7'b0, btn_level}, 8'h01);
    m_cnt = (m_cnt + 1) % 16; m_sticky = 1; m_level = 1;
    release_btn();
    do_in(16'h0AFF, 0, 0);
`endif

    repeat (4) @(posedge clk28);
    #1;
    check("scoreboard_drain", 8'(exp_q.size()), 8'h00);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
